// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the EX/MEM pipeline stage: default datapath width,
// buffer occupancy states and the layout of one buffered entry.
// The entry struct is sized from DATA_W_DEF, so a non-default DATA_W on
// ex_mem_stage needs DATA_W_DEF changed here as well.
package ex_mem_stage_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] alu_result;
      logic [DATA_W_DEF-1:0] store_data;
      logic [4:0]            rd_addr;
      logic                  mem_read;
      logic                  mem_write;
      logic                  reg_write;
   } entry_t;

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Two-entry in-order buffer between execute and memory stages.
// slot0 always holds the oldest entry; ready_o depends on registered state
// only, so there is no combinational path from pop_ready_i to ready_o.
module ex_mem_skid_buf
   import ex_mem_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push_i,
   input  entry_t entry_i,
   output logic   ready_o,
   output logic   valid_o,
   input  logic   pop_ready_i,
   output entry_t entry_o
);

   occ_e   state_q, state_d;
   entry_t slot0_q, slot0_d;
   entry_t slot1_q, slot1_d;
   logic   pop;

   // Occupancy and slot registers; reset empties the buffer and clears data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         state_q <= state_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end

   // Next occupancy and slot contents from push/pop; simultaneous push and pop keeps order.
   always_comb begin
      state_d = state_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      pop     = (state_q != EMPTY) && pop_ready_i;
      case (state_q)
         EMPTY: begin
            if (push_i) begin
               slot0_d = entry_i;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push_i && pop) begin
               slot0_d = entry_i;
            end else if (push_i) begin
               slot1_d = entry_i;
               state_d = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               slot0_d = slot1_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign ready_o = (state_q != TWO);
   assign valid_o = (state_q != EMPTY);
   assign entry_o = slot0_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: buffers non-branch execute results for the memory
// stage and resolves branches into a one-cycle fetch redirect.
// Optional feature macro: EX_MEM_BNE_EN enables BNE (in_branch_ne); without
// it every branch is treated as BEQ.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic              in_zero_flag,
   input  logic [DATA_W-1:0] in_rs2_data,
   input  logic [4:0]        in_rd_addr,
   input  logic              in_is_branch,
   input  logic              in_branch_ne,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_reg_write,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DATA_W-1:0] out_store_data,
   output logic [4:0]        out_rd_addr,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_reg_write,
   output logic              redirect_valid,
   output logic [DATA_W-1:0] redirect_pc
);

   logic              buf_ready;
   logic              accept;
   logic              taken;
   logic              push;
   entry_t            in_entry;
   entry_t            head;
   logic              redirect_valid_q, redirect_valid_d;
   logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

   assign in_ready = buf_ready;
   assign accept   = in_valid && buf_ready;

`ifdef EX_MEM_BNE_EN
   assign taken = in_branch_ne ? !in_zero_flag : in_zero_flag;
`else
   logic unused_branch_ne;
   assign unused_branch_ne = in_branch_ne;
   assign taken            = in_zero_flag;
`endif

   // Anything accepted while a redirect is being issued is wrong-path and dropped.
   assign push = accept && !in_is_branch && !redirect_valid_q;

   assign in_entry.alu_result = in_alu_result;
   assign in_entry.store_data = in_rs2_data;
   assign in_entry.rd_addr    = in_rd_addr;
   assign in_entry.mem_read   = in_mem_read;
   assign in_entry.mem_write  = in_mem_write;
   assign in_entry.reg_write  = in_reg_write;

   ex_mem_skid_buf u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .entry_i     (in_entry),
      .ready_o     (buf_ready),
      .valid_o     (out_valid),
      .pop_ready_i (out_ready),
      .entry_o     (head)
   );

   assign out_alu_result = head.alu_result;
   assign out_store_data = head.store_data;
   assign out_rd_addr    = head.rd_addr;
   assign out_mem_read   = head.mem_read;
   assign out_mem_write  = head.mem_write;
   assign out_reg_write  = head.reg_write;

   // Taken branch raises the redirect for one cycle; the target holds otherwise.
   always_comb begin
      redirect_valid_d = accept && in_is_branch && taken && !redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      if (redirect_valid_d) begin
         redirect_pc_d = in_pc + in_imm;
      end
   end

   // Redirect registers; reset cancels any pending redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule
